// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN package: data-field receiver states, payload limits, DLC decode
package can_pkg;

  localparam int unsigned CAN_MAX_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    RECEIVE  = 2'd2,
    COMPLETE = 2'd3
  } data_rx_state_t;

  // Payload bit count for a DLC; classic CAN saturates codes above the byte limit
  function automatic logic [6:0] dlc_to_bits(input logic [3:0] dlc,
                                             input int unsigned max_bytes = CAN_MAX_DATA_BYTES);
    int unsigned n;
    n = 32'(dlc);
    if (n > max_bytes) n = max_bytes;
    return 7'(n * 8);
  endfunction

endpackage

// File: rtl/data_field_rx_if.sv
// rtl/data_field_rx_if.sv - data-field receiver bus bundle; byte strobe ports under DATA_FIELD_RX_BYTE_STROBE_EN
interface data_field_rx_if;

  logic        enable;
  logic        sample_point;
  logic        stuff_bit_detected;
  logic        rx_bit;
  logic        control_complete;
  logic        frame_type;
  logic [3:0]  dlc;
  logic        abort;
  logic [63:0] data_out;
  logic [6:0]  bit_counter;
  logic        data_complete;
`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
  logic        byte_valid;
  logic [7:0]  byte_data;
`endif

  // Upstream side: bit timing / de-stuffing and the frame controller
  modport master (
    output enable, sample_point, stuff_bit_detected, rx_bit,
           control_complete, frame_type, dlc, abort,
    input  data_out, bit_counter, data_complete
`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
    , input byte_valid, byte_data
`endif
  );

  // Receiver side
  modport slave (
    input  enable, sample_point, stuff_bit_detected, rx_bit,
           control_complete, frame_type, dlc, abort,
    output data_out, bit_counter, data_complete
`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
    , output byte_valid, byte_data
`endif
  );

endinterface

// File: rtl/data_field_rx.sv
// rtl/data_field_rx.sv - CAN data-field receiver, MSB-first into a left-aligned 64-bit word; DATA_FIELD_RX_BYTE_STROBE_EN adds byte strobes
module data_field_rx
  import can_pkg::*;
#(
  parameter int unsigned MAX_BYTES = CAN_MAX_DATA_BYTES
) (
  input  logic           clock,
  input  logic           reset_n,
  data_field_rx_if.slave rx_if
);

  data_rx_state_t r_state;
  logic [6:0]     r_total_bits;
  logic [63:0]    r_shift;
  logic [6:0]     r_bit_counter;
  logic [63:0]    r_data_out;
  logic           r_data_complete;

  logic           w_accept;
  logic           w_last;
  logic [5:0]     w_wr_idx;
  logic [63:0]    w_shift_next;

  assign w_accept = (r_state == RECEIVE) && rx_if.sample_point && !rx_if.stuff_bit_detected;
  assign w_last   = w_accept && (r_bit_counter == (r_total_bits - 7'd1));
  assign w_wr_idx = 6'd63 - r_bit_counter[5:0];

  // Shift register image including the bit being accepted this cycle
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept) w_shift_next[w_wr_idx] = rx_if.rx_bit;
  end

  // Field FSM, capture register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_total_bits    <= '0;
      r_shift         <= '0;
      r_bit_counter   <= '0;
      r_data_out      <= '0;
      r_data_complete <= 1'b0;
    end else if (!rx_if.enable) begin
      r_state         <= IDLE;
      r_total_bits    <= '0;
      r_shift         <= '0;
      r_bit_counter   <= '0;
      r_data_out      <= '0;
      r_data_complete <= 1'b0;
    end else if (rx_if.abort) begin
      // Partial payload is dropped; data_out keeps the last good frame
      r_state         <= IDLE;
      r_data_complete <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_complete <= 1'b0;
          if (rx_if.control_complete) begin
            r_total_bits <= dlc_to_bits(rx_if.dlc, MAX_BYTES);
            if (rx_if.frame_type) begin
              // Remote frame carries no data: complete without touching data_out
              r_state         <= COMPLETE;
              r_bit_counter   <= '0;
              r_data_complete <= 1'b1;
            end else begin
              r_state <= ARM;
            end
          end
        end
        ARM: begin
          r_shift       <= '0;
          r_bit_counter <= '0;
          if (r_total_bits == 7'd0) begin
            r_state         <= COMPLETE;
            r_data_out      <= '0;
            r_data_complete <= 1'b1;
          end else begin
            r_state <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (w_accept) begin
            r_shift       <= w_shift_next;
            r_bit_counter <= r_bit_counter + 7'd1;
            if (w_last) begin
              r_state         <= COMPLETE;
              r_data_out      <= w_shift_next;
              r_data_complete <= 1'b1;
            end
          end
        end
        COMPLETE: begin
          r_state         <= IDLE;
          r_data_complete <= 1'b0;
        end
        default: begin
          r_state         <= IDLE;
          r_data_complete <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data_out      = r_data_out;
  assign rx_if.bit_counter   = r_bit_counter;
  assign rx_if.data_complete = r_data_complete;

`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
  logic       r_byte_valid;
  logic [7:0] r_byte_data;
  logic [6:0] r_byte_sr;

  // Per-byte strobe: fires the cycle after every eighth accepted bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_byte_sr    <= '0;
    end else if (!rx_if.enable) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_byte_sr    <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      if (!rx_if.abort && w_accept) begin
        r_byte_sr <= {r_byte_sr[5:0], rx_if.rx_bit};
        if (r_bit_counter[2:0] == 3'd7) begin
          r_byte_valid <= 1'b1;
          r_byte_data  <= {r_byte_sr, rx_if.rx_bit};
        end
      end
    end
  end

  assign rx_if.byte_valid = r_byte_valid;
  assign rx_if.byte_data  = r_byte_data;
`endif

endmodule

// File: tb/tb_data_field_rx.sv
// tb/tb_data_field_rx.sv - directed self-checking bench for data_field_rx
module tb_data_field_rx;

  logic clock;
  logic reset_n;
  int   tests;
  int   fails;
  int   dc_count;
  int   base;

  data_field_rx_if bus ();

  data_field_rx #(.MAX_BYTES(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx_if   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.data_complete === 1'b1) dc_count++;

`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
  logic [7:0] byte_q[$];
  always @(negedge clock) if (bus.byte_valid === 1'b1) byte_q.push_back(bus.byte_data);
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_ctrl(input logic [3:0] d, input logic remote);
    bus.control_complete = 1'b1;
    bus.dlc              = d;
    bus.frame_type       = remote;
    tick();
    bus.control_complete = 1'b0;
    bus.frame_type       = 1'b0;
    bus.dlc              = 4'hF;
  endtask

  // One idle cycle, then one sample-point cycle; returns just after the sampling edge
  task automatic send_bit(input logic b, input logic stuff);
    tick();
    bus.sample_point       = 1'b1;
    bus.rx_bit             = b;
    bus.stuff_bit_detected = stuff;
    tick();
    bus.sample_point       = 1'b0;
    bus.stuff_bit_detected = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] payload, input int first, input int n);
    for (int i = 0; i < n; i++) send_bit(payload[63 - first - i], 1'b0);
  endtask

  initial begin
    logic [15:0] two_bytes;
    tests = 0; fails = 0; dc_count = 0;
    reset_n = 1'b0;
    bus.enable = 1'b1; bus.sample_point = 1'b0; bus.stuff_bit_detected = 1'b0;
    bus.rx_bit = 1'b0; bus.control_complete = 1'b0; bus.frame_type = 1'b0;
    bus.dlc = 4'd0; bus.abort = 1'b0;
    tick(); tick();
    check("rst_data_out", bus.data_out, 64'd0);
    check("rst_bit_counter", 64'(bus.bit_counter), 64'd0);
    check("rst_data_complete", 64'(bus.data_complete), 64'd0);
`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
    check("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    check("rst_byte_data", 64'(bus.byte_data), 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // DLC=8 full payload; a sample point during ARM must be ignored
    base = dc_count;
    send_ctrl(4'd8, 1'b0);
    bus.sample_point = 1'b1; bus.rx_bit = 1'b0;
    tick();
    bus.sample_point = 1'b0;
    send_bits(64'hDEADBEEF_01234567, 0, 8);
    check("dlc8_mid_bit_counter", 64'(bus.bit_counter), 64'd8);
    check("dlc8_mid_no_complete", 64'(bus.data_complete), 64'd0);
    send_bits(64'hDEADBEEF_01234567, 8, 56);
    check("dlc8_complete", 64'(bus.data_complete), 64'd1);
    check("dlc8_data_out", bus.data_out, 64'hDEADBEEF_01234567);
    check("dlc8_bit_counter", 64'(bus.bit_counter), 64'd64);
    tick();
    check("dlc8_complete_drop", 64'(bus.data_complete), 64'd0);
    check("dlc8_pulse_count", 64'(dc_count - base), 64'd1);

    // DLC=2 with three stuff bits interleaved
    send_ctrl(4'd2, 1'b0);
    tick();
    two_bytes = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      if (i == 4 || i == 9 || i == 14) send_bit(~two_bytes[15 - i], 1'b1);
      send_bit(two_bytes[15 - i], 1'b0);
    end
    check("dlc2_complete", 64'(bus.data_complete), 64'd1);
    check("dlc2_data_out", bus.data_out, 64'hA53C_0000_0000_0000);
    check("dlc2_bit_counter", 64'(bus.bit_counter), 64'd16);
    tick();

    // Remote frame: completes one cycle after control_complete, payload untouched
    send_ctrl(4'd4, 1'b1);
    check("remote_complete", 64'(bus.data_complete), 64'd1);
    check("remote_bit_counter", 64'(bus.bit_counter), 64'd0);
    check("remote_data_out", bus.data_out, 64'hA53C_0000_0000_0000);
    tick();
    check("remote_complete_drop", 64'(bus.data_complete), 64'd0);

    // DLC=0: complete two cycles after control_complete, empty payload
    send_ctrl(4'd0, 1'b0);
    check("dlc0_arm_no_complete", 64'(bus.data_complete), 64'd0);
    tick();
    check("dlc0_complete", 64'(bus.data_complete), 64'd1);
    check("dlc0_data_out", bus.data_out, 64'd0);
    check("dlc0_bit_counter", 64'(bus.bit_counter), 64'd0);
    tick();

    // DLC=15 saturates to 64 bits
    send_ctrl(4'd15, 1'b0);
    tick();
    send_bits(64'h01234567_89ABCDEF, 0, 63);
    check("dlc15_not_yet", 64'(bus.data_complete), 64'd0);
    check("dlc15_bc63", 64'(bus.bit_counter), 64'd63);
    send_bits(64'h01234567_89ABCDEF, 63, 1);
    check("dlc15_complete", 64'(bus.data_complete), 64'd1);
    check("dlc15_data_out", bus.data_out, 64'h01234567_89ABCDEF);
    check("dlc15_bit_counter", 64'(bus.bit_counter), 64'd64);
    tick();

    // Abort after 20 bits; later sample points must not resume reception
    base = dc_count;
    send_ctrl(4'd8, 1'b0);
    tick();
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 20);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 50);
    check("abort_no_complete", 64'(dc_count - base), 64'd0);
    check("abort_data_kept", bus.data_out, 64'h01234567_89ABCDEF);

    // DLC=1 after abort
    send_ctrl(4'd1, 1'b0);
    tick();
    send_bits(64'h5A00_0000_0000_0000, 0, 8);
    check("dlc1_complete", 64'(bus.data_complete), 64'd1);
    check("dlc1_data_out", bus.data_out, 64'h5A00_0000_0000_0000);
    check("dlc1_bit_counter", 64'(bus.bit_counter), 64'd8);
    tick();

    // Abort coincident with the final accept wins
    base = dc_count;
    send_ctrl(4'd1, 1'b0);
    tick();
    send_bits(64'hC300_0000_0000_0000, 0, 7);
    tick();
    bus.sample_point = 1'b1; bus.rx_bit = 1'b1; bus.abort = 1'b1;
    tick();
    bus.sample_point = 1'b0; bus.abort = 1'b0;
    check("abort_final_no_complete", 64'(bus.data_complete), 64'd0);
    tick(); tick();
    check("abort_final_count", 64'(dc_count - base), 64'd0);
    check("abort_final_data_kept", bus.data_out, 64'h5A00_0000_0000_0000);

    // Enable drop mid-field clears state; no resume without a new control_complete
    base = dc_count;
    send_ctrl(4'd8, 1'b0);
    tick();
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 10);
    bus.enable = 1'b0;
    tick();
    check("disable_data_out", bus.data_out, 64'd0);
    check("disable_bit_counter", 64'(bus.bit_counter), 64'd0);
    check("disable_data_complete", 64'(bus.data_complete), 64'd0);
    bus.enable = 1'b1;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 54);
    check("disable_no_resume", 64'(dc_count - base), 64'd0);

`ifdef DATA_FIELD_RX_BYTE_STROBE_EN
    byte_q.delete();
    send_ctrl(4'd3, 1'b0);
    tick();
    send_bits(64'h112233_0000000000, 0, 24);
    check("bytes_data_out", bus.data_out, 64'h112233_0000000000);
    tick();
    check("bytes_count", 64'(byte_q.size()), 64'd3);
    if (byte_q.size() == 3) begin
      check("byte0", 64'(byte_q[0]), 64'h11);
      check("byte1", 64'(byte_q[1]), 64'h22);
      check("byte2", 64'(byte_q[2]), 64'h33);
    end
    check("byte_data_hold", 64'(bus.byte_data), 64'h33);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
